rv32m_multiply_unit: RTL and testbench
======================================

Name: rv32m_multiply_unit

Overview:
- RV32M multiply front-end in the EX stage. Executes MUL/MULH/MULHSU/MULHU using an internal 33x33 dsp_tiled_multiplier_unsigned instance.
- Converts signed operands to magnitudes and issues them to the multiplier.
- Restores the sign of the 64-bit product with 32-bit chunked negation (registered carry), selects the result word, and returns it with a tag.
- Sits between issue/dispatch and writeback.

Parameters:
TAG_WIDTH, 5, width of the opaque tag carried from request to result.

Ports:
i_clk  input  1  clock
i_rst  input  1  reset
i_valid  input  1  request valid
o_ready  output  1  unit can accept a request
i_op  input  2  00 MUL, 01 MULH, 10 MULHSU, 11 MULHU
i_rs1  input  32  operand 1
i_rs2  input  32  operand 2
i_tag  input  TAG_WIDTH  request tag
i_flush  input  1  discard the in-flight or offered request
o_valid  output  1  one-cycle result pulse
o_result  output  32  result word
o_tag  output  TAG_WIDTH  tag of the result
o_completing_next_cycle  output  1  o_valid will assert next cycle

Behaviour:
- Reset: i_rst is synchronous, active-high; clock is i_clk. Reset also resets the multiplier instance.
- Reset values: state=IDLE, o_valid=0, o_result=0, o_tag=0, discard=0. No request is accepted while i_rst=1.
- o_ready = (state==IDLE) && !i_rst.
- Accept condition: i_valid && o_ready && !i_flush. Flush has priority, so an offered request is dropped.
- Operand signedness:
  - rs1 is signed for MULH and MULHSU.
  - rs2 is signed for MULH only.
  - MUL treats both operands as unsigned; the low word is identical regardless.
- On accept (cycle N):
  - Register |rs1| and |rs2|. Magnitudes are 32-bit; |0x80000000| = 0x80000000.
  - Zero-extend both to 33 bits.
  - Register neg = sign1 XOR sign2, plus op and tag.
  - Go to ISSUE.
- States:
  - ISSUE (N+1): drive the multiplier's i_valid_input=1 for exactly one cycle, then go to WAIT.
  - WAIT: hold until the multiplier's o_valid_output (N+6). Capture the 64 low product bits, then go to FIX_LO.
  - FIX_LO (N+7):
    - If neg: lo = ~lo + 1. Register carry-out.
    - Else pass lo through, carry=0.
  - FIX_HI (N+8):
    - If neg: hi = ~hi + carry.
    - Register o_result (lo for MUL, hi otherwise) and o_tag.
    - Set o_valid=1 for the next cycle and go to IDLE.
- Timing: o_valid is high in N+9, and o_ready is already high in N+9, so back-to-back throughput is one request per 9 cycles.
- o_completing_next_cycle = (state==FIX_HI) && !discard && !i_flush.
- Product zero with neg=1: the negation yields 0, with no spurious carry into hi.
- Flush (i_flush=1):
  - IDLE: no effect beyond blocking acceptance.
  - ISSUE: return to IDLE next cycle; the multiplier is not issued.
  - WAIT: set discard. The multiplier cannot abort, so stay in WAIT until its o_valid_output, then go to IDLE without a result.
  - FIX_LO/FIX_HI: go to IDLE next cycle; no o_valid.
  - A flush during a discarded WAIT is harmless.
  - o_valid is never asserted for a flushed request.
- Reset mid-operation: immediate return to reset values; no stale multiplier result is ever reported.

Optional Feature:
- Macro: RV32M_MUL_OPERAND_REUSE_EN.
- Enabled:
  - Keep a cache of the last completed, unflushed request: rs1, rs2, signedness class and final signed 64-bit product, plus a valid bit.
  - Cache valid is cleared on reset.
  - Hit condition: rs1 and rs2 equal, and (op equal OR new op==MUL).
  - On an accepted hit in cycle N: register the result from the cache, o_valid in N+1, state stays IDLE, o_completing_next_cycle not asserted.
  - A flush in the accept cycle suppresses the hit.
- Disabled: no cache; every request takes the 9-cycle path.

Test Plan:
- MULH rs1=0xFFFFFFF9 (-7), rs2=3 accepted cycle N -> o_valid in N+9 exactly, o_result=0xFFFFFFFF. Then MUL with the same operands -> 0xFFFFFFEB, tag echoed.
- Corner values:
  - MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE.
  - MULH 0x80000000 x 0x80000000 -> 0x40000000.
  - MULHSU 0x80000000 x 2 -> 0xFFFFFFFF.
  - MULH 0 x 0xFFFFFFFB -> 0x00000000.
- o_completing_next_cycle: high only in N+8. o_ready low in N+1..N+8, high in N+9; a new request accepted in N+9 completes in N+18.
- Flush in ISSUE -> o_ready in N+2, no o_valid.
- Flush in WAIT -> no o_valid, o_ready returns the cycle after the multiplier's o_valid_output.
- Flush with i_valid in IDLE -> request not accepted.
- Reset asserted in N+4 -> all outputs 0 next cycle. A new MULHU 5x7 after reset -> o_result 0, with o_valid 9 cycles after accept.
- With RV32M_MUL_OPERAND_REUSE_EN:
  - MULH(-7,3) then MUL(-7,3) -> second result 0xFFFFFFEB, o_valid one cycle after accept.
  - MULHU after MULH with the same operands -> full 9-cycle path.

Source files
------------

// File: rtl/rv32m_multiply_unit.sv
// rtl/rv32m_multiply_unit.sv - RV32M MUL/MULH/MULHSU/MULHU front-end around a 33x33 tiled multiplier
//
// Purpose: takes a multiply request from issue, converts signed operands to
// magnitudes, runs them through a pipelined unsigned 33x33 multiplier, restores
// the sign of the 64-bit product with a two-step 32-bit negation, and returns
// the selected word with the request tag as a one-cycle pulse.
//
// Ports (rv32m_multiply_unit):
//   i_clk, i_rst             clock, synchronous active-high reset
//   i_valid / o_ready        request handshake
//   i_op                     00 MUL, 01 MULH, 10 MULHSU, 11 MULHU
//   i_rs1, i_rs2, i_tag      request operands and opaque tag
//   i_flush                  drop the offered or in-flight request
//   o_valid, o_result, o_tag one-cycle result pulse with result word and tag
//   o_completing_next_cycle  o_valid will assert on the next cycle
//
// Optional feature macro: RV32M_MUL_OPERAND_REUSE_EN (last-result reuse cache).

module dsp_tiled_multiplier_unsigned (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_valid_input,
  input  logic [32:0] i_a,
  input  logic [32:0] i_b,
  output logic        o_valid_output,
  output logic [65:0] o_product
);
  // Five-stage pipeline: input register, 17/16-bit tile products, tile sum,
  // then two balancing registers so o_valid_output lands 5 cycles after issue.
  logic [32:0] a_q, b_q;
  logic [33:0] pp_ll_q;
  logic [32:0] pp_lh_q, pp_hl_q;
  logic [31:0] pp_hh_q;
  logic [65:0] sum_q, dly_q, prod_q;
  logic [4:0]  vld_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      vld_q <= '0;
    end else begin
      vld_q <= {vld_q[3:0], i_valid_input};
    end
    a_q     <= i_a;
    b_q     <= i_b;
    pp_ll_q <= {17'd0, a_q[16:0]}  * {17'd0, b_q[16:0]};
    pp_lh_q <= {16'd0, a_q[16:0]}  * {17'd0, b_q[32:17]};
    pp_hl_q <= {17'd0, a_q[32:17]} * {16'd0, b_q[16:0]};
    pp_hh_q <= {16'd0, a_q[32:17]} * {16'd0, b_q[32:17]};
    sum_q   <= {32'd0, pp_ll_q}
             + ({33'd0, pp_lh_q} << 17)
             + ({33'd0, pp_hl_q} << 17)
             + ({34'd0, pp_hh_q} << 34);
    dly_q   <= sum_q;
    prod_q  <= dly_q;
  end

  assign o_valid_output = vld_q[4];
  assign o_product      = prod_q;
endmodule

module rv32m_multiply_unit #(
  parameter int TAG_WIDTH = 5
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [1:0]           i_op,
  input  logic [31:0]          i_rs1,
  input  logic [31:0]          i_rs2,
  input  logic [TAG_WIDTH-1:0] i_tag,
  input  logic                 i_flush,
  output logic                 o_valid,
  output logic [31:0]          o_result,
  output logic [TAG_WIDTH-1:0] o_tag,
  output logic                 o_completing_next_cycle
);
  localparam logic [1:0] OP_MUL    = 2'b00;
  localparam logic [1:0] OP_MULH   = 2'b01;
  localparam logic [1:0] OP_MULHSU = 2'b10;

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_FIX_LO, S_FIX_HI} state_t;

  state_t                state_q;
  logic [31:0]           mag1_q, mag2_q;
  logic                  neg_q;
  logic [1:0]            op_q;
  logic [TAG_WIDTH-1:0]  tag_q;
  logic                  discard_q;
  logic [31:0]           lo_q, hi_q;
  logic                  carry_q;
  logic                  o_valid_q;
  logic [31:0]           o_result_q;
  logic [TAG_WIDTH-1:0]  o_tag_q;

  logic        sign1, sign2, accept, mul_issue, mul_valid;
  logic [31:0] mag1_d, mag2_d, hi_fix_d, result_d;
  logic [32:0] lo_neg_d;
  logic [65:0] mul_product;
  logic        unused_product_msbs;
  logic        cache_hit;
  logic [31:0] cache_result;

  assign o_ready   = (state_q == S_IDLE) && !i_rst;
  assign accept    = i_valid && o_ready && !i_flush;
  assign sign1     = i_rs1[31] && ((i_op == OP_MULH) || (i_op == OP_MULHSU));
  assign sign2     = i_rs2[31] && (i_op == OP_MULH);
  assign mag1_d    = sign1 ? (~i_rs1 + 32'd1) : i_rs1;
  assign mag2_d    = sign2 ? (~i_rs2 + 32'd1) : i_rs2;
  // A flush in ISSUE must keep the multiplier from starting at all.
  assign mul_issue = (state_q == S_ISSUE) && !i_flush;

  // Low-word negation carries into the high word one cycle later; a zero
  // product produces carry 1 into ~0, which correctly wraps the high word to 0.
  assign lo_neg_d  = {1'b0, ~lo_q} + 33'd1;
  assign hi_fix_d  = neg_q ? (~hi_q + {31'd0, carry_q}) : hi_q;
  assign result_d  = (op_q == OP_MUL) ? lo_q : hi_fix_d;

  assign unused_product_msbs = ^mul_product[65:64];

  dsp_tiled_multiplier_unsigned u_mul (
    .i_clk          (i_clk),
    .i_rst          (i_rst),
    .i_valid_input  (mul_issue),
    .i_a            ({1'b0, mag1_q}),
    .i_b            ({1'b0, mag2_q}),
    .o_valid_output (mul_valid),
    .o_product      (mul_product)
  );

`ifdef RV32M_MUL_OPERAND_REUSE_EN
  logic        cache_valid_q;
  logic [31:0] cache_rs1_q, cache_rs2_q, rs1_q, rs2_q;
  logic [1:0]  cache_op_q;
  logic [63:0] cache_prod_q;

  // MUL only needs the low word, which is the same for every signedness class.
  assign cache_hit    = cache_valid_q && (i_rs1 == cache_rs1_q) && (i_rs2 == cache_rs2_q)
                     && ((i_op == cache_op_q) || (i_op == OP_MUL));
  assign cache_result = (i_op == OP_MUL) ? cache_prod_q[31:0] : cache_prod_q[63:32];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cache_valid_q <= 1'b0;
      cache_rs1_q   <= '0;
      cache_rs2_q   <= '0;
      cache_op_q    <= '0;
      cache_prod_q  <= '0;
      rs1_q         <= '0;
      rs2_q         <= '0;
    end else begin
      if (accept && !cache_hit) begin
        rs1_q <= i_rs1;
        rs2_q <= i_rs2;
      end
      if ((state_q == S_FIX_HI) && !i_flush) begin
        cache_valid_q <= 1'b1;
        cache_rs1_q   <= rs1_q;
        cache_rs2_q   <= rs2_q;
        cache_op_q    <= op_q;
        cache_prod_q  <= {hi_fix_d, lo_q};
      end
    end
  end
`else
  assign cache_hit    = 1'b0;
  assign cache_result = 32'd0;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= S_IDLE;
      mag1_q     <= '0;
      mag2_q     <= '0;
      neg_q      <= 1'b0;
      op_q       <= '0;
      tag_q      <= '0;
      discard_q  <= 1'b0;
      lo_q       <= '0;
      hi_q       <= '0;
      carry_q    <= 1'b0;
      o_valid_q  <= 1'b0;
      o_result_q <= '0;
      o_tag_q    <= '0;
    end else begin
      o_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            if (cache_hit) begin
              o_valid_q  <= 1'b1;
              o_result_q <= cache_result;
              o_tag_q    <= i_tag;
            end else begin
              mag1_q  <= mag1_d;
              mag2_q  <= mag2_d;
              neg_q   <= sign1 ^ sign2;
              op_q    <= i_op;
              tag_q   <= i_tag;
              state_q <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          state_q <= i_flush ? S_IDLE : S_WAIT;
        end
        S_WAIT: begin
          // The multiplier cannot be aborted; a flush here only marks the
          // eventual product for discard.
          if (i_flush) begin
            discard_q <= 1'b1;
          end
          if (mul_valid) begin
            lo_q <= mul_product[31:0];
            hi_q <= mul_product[63:32];
            if (discard_q || i_flush) begin
              discard_q <= 1'b0;
              state_q   <= S_IDLE;
            end else begin
              state_q <= S_FIX_LO;
            end
          end
        end
        S_FIX_LO: begin
          if (i_flush) begin
            state_q <= S_IDLE;
          end else begin
            lo_q    <= neg_q ? lo_neg_d[31:0] : lo_q;
            carry_q <= neg_q ? lo_neg_d[32] : 1'b0;
            state_q <= S_FIX_HI;
          end
        end
        S_FIX_HI: begin
          state_q <= S_IDLE;
          if (!i_flush) begin
            o_valid_q  <= 1'b1;
            o_result_q <= result_d;
            o_tag_q    <= tag_q;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign o_valid                 = o_valid_q;
  assign o_result                = o_result_q;
  assign o_tag                   = o_tag_q;
  assign o_completing_next_cycle = (state_q == S_FIX_HI) && !discard_q && !i_flush;
endmodule

// File: tb/tb_rv32m_multiply_unit.sv
// tb/tb_rv32m_multiply_unit.sv - randomized self-checking bench for rv32m_multiply_unit
module tb_rv32m_multiply_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic        i_valid;
  logic        o_ready;
  logic [1:0]  op;
  logic [31:0] rs1, rs2;
  logic [4:0]  tag;
  logic        i_flush;
  logic        o_valid;
  logic [31:0] o_result;
  logic [4:0]  o_tag;
  logic        o_completing;

  int n_checks = 0;
  int n_pass   = 0;

  bit          mc_valid = 1'b0;
  logic [31:0] mc_a, mc_b;
  logic [1:0]  mc_op;

  rv32m_multiply_unit #(.TAG_WIDTH(5)) dut (
    .i_clk                   (clk),
    .i_rst                   (rst),
    .i_valid                 (i_valid),
    .o_ready                 (o_ready),
    .i_op                    (op),
    .i_rs1                   (rs1),
    .i_rs2                   (rs2),
    .i_tag                   (tag),
    .i_flush                 (i_flush),
    .o_valid                 (o_valid),
    .o_result                (o_result),
    .o_tag                   (o_tag),
    .o_completing_next_cycle (o_completing)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", name, got, exp);
  endtask

  // Architectural reference: sign- or zero-extend to 64 bits and multiply.
  function automatic logic [31:0] ref_result(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, p;
    sa = (o == 2'b01 || o == 2'b10) ? longint'($signed(a)) : longint'({32'd0, a});
    sb = (o == 2'b01) ? longint'($signed(b)) : longint'({32'd0, b});
    p  = sa * sb;
    return (o == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  task automatic offer(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input logic [4:0] t);
    int bound;
    bound = 0;
    while (!o_ready && bound < 30) begin
      @(negedge clk);
      bound++;
    end
    check_eq("ready_wait_bound", 64'(bound < 30), 64'd1);
    i_valid = 1'b1; op = o; rs1 = a; rs2 = b; tag = t;
    @(posedge clk);
    #1 i_valid = 1'b0;
  endtask

  task automatic run_req(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] t, output logic [31:0] got);
    int k_valid, k_comp, k_ready;
    bit hit;
    logic [4:0] got_tag;
    hit = 1'b0;
`ifdef RV32M_MUL_OPERAND_REUSE_EN
    hit = mc_valid && (a == mc_a) && (b == mc_b) && ((o == mc_op) || (o == 2'b00));
`endif
    offer(o, a, b, t);
    k_valid = -1; k_comp = -1; k_ready = -1;
    got = '0; got_tag = '0;
    for (int k = 0; k < 20 && k_valid < 0; k++) begin
      @(negedge clk);
      if (o_completing && k_comp < 0) k_comp = k;
      if (o_ready && k_ready < 0) k_ready = k;
      if (o_valid) begin
        k_valid = k;
        got     = o_result;
        got_tag = o_tag;
      end
    end
    check_eq("latency",    64'(k_valid), hit ? 64'd0 : 64'd8);
    check_eq("completing", 64'(k_comp),  hit ? 64'(-1) : 64'd7);
    check_eq("ready_back", 64'(k_ready), hit ? 64'd0 : 64'd8);
    check_eq("result",     64'(got),     64'(ref_result(o, a, b)));
    check_eq("tag",        64'(got_tag), 64'(t));
    if (!hit) begin
      mc_valid = 1'b1; mc_a = a; mc_b = b; mc_op = o;
    end
  endtask

  // Watch n cycles after an accept, pulsing i_flush during cycle index flush_at.
  task automatic watch(input int n, input int flush_at, output int k_ready, output int n_valid);
    k_ready = -1; n_valid = 0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (o_ready && k_ready < 0) k_ready = k;
      if (o_valid) n_valid++;
      i_flush = (k == flush_at);
    end
    i_flush = 1'b0;
  endtask

  logic [31:0] corners [8] = '{32'h0, 32'h1, 32'h2, 32'h7FFFFFFF,
                               32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFF9, 32'h3};

  initial begin
    logic [31:0] r, a, b;
    logic [1:0]  o;
    int kr, nv;
    rst = 1'b1; i_valid = 1'b0; i_flush = 1'b0; op = '0; rs1 = '0; rs2 = '0; tag = '0;
    repeat (3) @(negedge clk);
    check_eq("rst_ready",  64'(o_ready),      64'd0);
    check_eq("rst_valid",  64'(o_valid),      64'd0);
    check_eq("rst_result", 64'(o_result),     64'd0);
    check_eq("rst_tag",    64'(o_tag),        64'd0);
    check_eq("rst_comp",   64'(o_completing), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_eq("post_rst_ready", 64'(o_ready), 64'd1);

    // Directed: these run back-to-back, so the second accept lands in N+9.
    run_req(2'b01, 32'hFFFFFFF9, 32'd3, 5'd5, r);
    check_eq("mulh_m7x3", 64'(r), 64'hFFFFFFFF);
    run_req(2'b00, 32'hFFFFFFF9, 32'd3, 5'd6, r);
    check_eq("mul_m7x3", 64'(r), 64'hFFFFFFEB);
    run_req(2'b11, 32'hFFFFFFF9, 32'd3, 5'd7, r);
    check_eq("mulhu_m7x3", 64'(r), 64'h2);
    run_req(2'b01, 32'h80000000, 32'h80000000, 5'd8, r);
    check_eq("mulh_min_min", 64'(r), 64'h40000000);
    run_req(2'b10, 32'h80000000, 32'd2, 5'd10, r);
    check_eq("mulhsu_min_2", 64'(r), 64'hFFFFFFFF);
    run_req(2'b01, 32'd0, 32'hFFFFFFFB, 5'd11, r);
    check_eq("mulh_zero_neg", 64'(r), 64'h0);
    run_req(2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd9, r);
    check_eq("mulhu_max", 64'(r), 64'hFFFFFFFE);

    // Flush in ISSUE: back to IDLE in N+2, no result.
    offer(2'b11, 32'h1234, 32'h5678, 5'd12);
    watch(14, 0, kr, nv);
    check_eq("flush_issue_ready", 64'(kr), 64'd1);
    check_eq("flush_issue_nvalid", 64'(nv), 64'd0);

    // Flush in WAIT: ready returns in N+7, the cycle after the product emerges.
    offer(2'b01, 32'hDEADBEEF, 32'h0BADF00D, 5'd13);
    watch(16, 2, kr, nv);
    check_eq("flush_wait_ready", 64'(kr), 64'd6);
    check_eq("flush_wait_nvalid", 64'(nv), 64'd0);

    // Flush in FIX_LO (N+7).
    offer(2'b00, 32'h11111111, 32'h3, 5'd14);
    watch(14, 6, kr, nv);
    check_eq("flush_fixlo_ready", 64'(kr), 64'd7);
    check_eq("flush_fixlo_nvalid", 64'(nv), 64'd0);

    // Offer with flush in IDLE is dropped.
    i_valid = 1'b1; i_flush = 1'b1; op = 2'b11; rs1 = 32'd9; rs2 = 32'd9; tag = 5'd15;
    @(posedge clk);
    #1 i_valid = 1'b0; i_flush = 1'b0;
    watch(12, -1, kr, nv);
    check_eq("flush_idle_ready", 64'(kr), 64'd0);
    check_eq("flush_idle_nvalid", 64'(nv), 64'd0);

    // Reset mid-operation right after a nonzero result with a nonzero tag.
    run_req(2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd17, r);
    offer(2'b01, 32'hFFFFFFF9, 32'd3, 5'd18);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1 check_eq("midrst_ready_low", 64'(o_ready), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    mc_valid = 1'b0;
    @(negedge clk);
    check_eq("midrst_valid",  64'(o_valid),      64'd0);
    check_eq("midrst_result", 64'(o_result),     64'd0);
    check_eq("midrst_tag",    64'(o_tag),        64'd0);
    check_eq("midrst_comp",   64'(o_completing), 64'd0);
    check_eq("midrst_ready",  64'(o_ready),      64'd1);
    run_req(2'b11, 32'd5, 32'd7, 5'd19, r);
    check_eq("mulhu_5x7", 64'(r), 64'h0);

    // Randomized traffic, with operand reuse to exercise repeated operands.
    a = 32'd0; b = 32'd0;
    for (int i = 0; i < 40; i++) begin
      o = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 3))
        0: begin a = $urandom; b = $urandom; end
        1: begin a = corners[$urandom_range(0, 7)]; b = corners[$urandom_range(0, 7)]; end
        2: begin a = corners[$urandom_range(0, 7)]; b = $urandom; end
        default: ;
      endcase
      run_req(o, a, b, 5'($urandom), r);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
